// File: rtl/tile_stream_reader.sv
// Streams a ROW_N x COL_N tile from a sync-read buffer in (optionally mirrored) raster order.
// First pixel 3 cycles after start; a 2-entry skid buffer plus read credits give 1 pixel/cycle under out_ready.
module tile_stream_reader #(
   parameter int ROW_N  = 32,
   parameter int COL_N  = 32,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              flip_h,
   input  logic              flip_v,
   output logic              busy,
   output logic              done,
   output logic              ce_mem,
   output logic [ADDR_W-1:0] addr_mem,
   input  logic [DATA_W-1:0] data_mem,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sol,
   output logic              out_eol,
   output logic              out_eof
);

   localparam int RW = (ROW_N > 1) ? $clog2(ROW_N) : 1;
   localparam int CW = (COL_N > 1) ? $clog2(COL_N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] dat;
      logic              sol;
      logic              eol;
      logic              eof;
   } pix_t;

   state_t            state_q, state_d;
   logic              flip_h_q, flip_h_d;
   logic              flip_v_q, flip_v_d;
   logic [RW-1:0]     r_q, r_d;
   logic [CW-1:0]     c_q, c_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inflight_q, inflight_d;
   logic [2:0]        mark_q, mark_d;
   logic [1:0]        count_q, count_d;
   pix_t              head_q, head_d;
   pix_t              tail_q, tail_d;
   logic              done_q, done_d;

   logic              out_vld;
   logic              pop;
   logic              issue;
   logic              last_pix;
   logic [2:0]        credit_used;
   logic [RW-1:0]     rr;
   logic [CW-1:0]     cc;
   logic [ADDR_W-1:0] addr_calc;
   pix_t              new_pix;

   always_comb begin
      state_d    = state_q;
      flip_h_d   = flip_h_q;
      flip_v_d   = flip_v_q;
      r_d        = r_q;
      c_d        = c_q;
      addr_d     = addr_q;
      inflight_d = 1'b0;
      mark_d     = mark_q;
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;
      done_d     = 1'b0;

      out_vld  = (count_q != 2'd0);
      pop      = out_vld & out_ready;
      last_pix = (r_q == RW'(ROW_N - 1)) && (c_q == CW'(COL_N - 1));

      // A pop in the same cycle frees a slot, so it counts as a returned credit.
      credit_used = 3'(count_q) + 3'(inflight_q) - 3'(pop);
      issue       = (state_q == RUN) && (credit_used < 3'd2);

      rr        = flip_v_q ? (RW'(ROW_N - 1) - r_q) : r_q;
      cc        = flip_h_q ? (CW'(COL_N - 1) - c_q) : c_q;
      addr_calc = (ADDR_W'(rr) << CW) | ADDR_W'(cc);

      new_pix = {data_mem, mark_q};

      inflight_d = issue;
      if (issue) begin
         addr_d = addr_calc;
         mark_d = {c_q == '0, c_q == CW'(COL_N - 1), last_pix};
         if (c_q == CW'(COL_N - 1)) begin
            c_d = '0;
            r_d = r_q + 1'b1;
         end else begin
            c_d = c_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            // done_q marks the done cycle, where a new start is still refused.
            if (start && !done_q) begin
               state_d  = RUN;
               flip_h_d = flip_h;
               flip_v_d = flip_v;
               r_d      = '0;
               c_d      = '0;
            end
         end
         RUN: begin
            if (issue && last_pix) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head_q.eof) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      case ({inflight_q, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d = new_pix;
            end else begin
               tail_d = new_pix;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               head_d = new_pix;
            end else begin
               head_d = tail_q;
               tail_d = new_pix;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         flip_h_q   <= 1'b0;
         flip_v_q   <= 1'b0;
         r_q        <= '0;
         c_q        <= '0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         mark_q     <= '0;
         count_q    <= 2'd0;
         head_q     <= '0;
         tail_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         flip_h_q   <= flip_h_d;
         flip_v_q   <= flip_v_d;
         r_q        <= r_d;
         c_q        <= c_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         mark_q     <= mark_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         done_q     <= done_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign ce_mem    = issue;
   assign addr_mem  = issue ? addr_calc : addr_q;
   assign out_valid = out_vld;
   assign out_data  = head_q.dat;
   assign out_sol   = out_vld & head_q.sol;
   assign out_eol   = out_vld & head_q.eol;
   assign out_eof   = out_vld & head_q.eof;

endmodule

// File: doc/tile_stream_reader.md
Name: tile_stream_reader

Overview:
- Downstream consumer of the 32x32 destination tile buffer filled by the crop transfer stage.
- On `start`, reads the whole tile from the buffer's synchronous-read port and emits pixels in raster order on a valid/ready stream.
- Stream carries start-of-line, end-of-line and end-of-frame markers.
- Optional horizontal and vertical mirroring of the read order, sampled at `start`.
- Absorbs downstream backpressure with a 2-entry output buffer and credit-based read issue.

Parameters:
- ROW_N, 32, tile rows.
- COL_N, 32, tile columns; power of two.
- ADDR_W, 10, buffer address width; must be >= clog2(ROW_N*COL_N).
- DATA_W, 8, pixel width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle request to stream a tile; ignored while busy=1.
- flip_h  input  1  mirror column order; sampled when start is accepted.
- flip_v  input  1  mirror row order; sampled when start is accepted.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last pixel handshake.
- ce_mem  output  1  buffer read enable.
- addr_mem  output  ADDR_W  buffer read address.
- data_mem  input  DATA_W  read data; valid exactly 1 cycle after ce_mem=1.
- out_valid  output  1  stream data valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  pixel.
- out_sol  output  1  first pixel of a line; qualified by out_valid.
- out_eol  output  1  last pixel of a line; qualified by out_valid.
- out_eof  output  1  last pixel of the tile; qualified by out_valid.

Behaviour:
- Reset (rst=1 at an edge):
  - Outputs next cycle: busy, done, ce_mem, out_valid, out_sol, out_eol, out_eof = 0; addr_mem, out_data = 0.
  - FSM goes to IDLE; buffer count and in-flight flag are cleared.
  - Mid-operation reset discards any in-flight read and buffered pixels; no done pulse is produced.
- FSM states IDLE, RUN, DRAIN:
  - IDLE -> RUN when start=1; latch flip_h/flip_v; clear row/col counters r, c to 0.
  - RUN: issue reads; RUN -> DRAIN on the cycle the read of pixel ROW_N*COL_N-1 is issued.
  - DRAIN: no new reads; DRAIN -> IDLE on the handshake of the out_eof pixel; done=1 in the following cycle.
- Handshake:
  - A handshake occurs when out_valid & out_ready.
  - out_data and the marker signals are held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
- Read issue:
  - ce_mem=1 in a RUN cycle iff (count + inflight - pop) < 2.
  - count = entries in the 2-entry buffer; inflight = read issued last cycle; pop = handshake this cycle.
  - Credits therefore include a pop in the same cycle, which gives a sustained 1 pixel/cycle when out_ready=1.
  - The buffer never overflows.
- Address:
  - Row index rr = flip_v ? ROW_N-1-r : r; column index cc = flip_h ? COL_N-1-c : c.
  - addr_mem = rr*COL_N + cc (shift/concatenate).
  - c wraps COL_N-1 -> 0 and r increments.
  - addr_mem holds its last value when ce_mem=0.
- Markers:
  - Computed from the unmirrored (r, c) at issue time.
  - sol: c==0. eol: c==COL_N-1. eof: r==ROW_N-1 and c==COL_N-1.
  - Markers are pipelined alongside the read.
- Buffer:
  - A read issued in cycle N has data_mem captured at the end of cycle N+1; out_valid can rise in cycle N+2.
  - Simultaneous push and pop with count=1 or 2 is legal; count is unchanged.
  - The buffer head always drives the out_* signals.
- Latency:
  - Start accepted at edge k: busy=1 and the first ce_mem=1 (addr for r=0, c=0) in cycle k+1.
  - First out_valid in cycle k+3.
- Start conditions:
  - start during busy is ignored, including in the done cycle; busy=0 in the done cycle.
  - start in the same cycle as rst: reset wins.

Test Plan:
- No mirror, out_ready=1 constantly, start at edge k:
  - ce_mem high cycles k+1..k+1024 with addr 0..1023.
  - 1024 consecutive handshakes in cycles k+3..k+1026; out_data = buffer[addr] in order.
  - done=1 in cycle k+1027 only.
- Markers:
  - sol on pixels 0, 32, …, 992; eol on pixels 31, 63, …, 1023; eof only on pixel 1023.
- Backpressure:
  - out_ready toggled 1-cycle on/3-cycles off, plus a 20-cycle stall mid-line.
  - All 1024 pixels are delivered once, in order, with no loss or duplicate.
  - ce_mem never fires when the credit is 0; out_data is stable during stalls.
- flip_h=1, flip_v=1 (buffer preloaded with data = addr[7:0]):
  - First address 1023, second 1022, pixel 32 at address 991, last address 0.
  - Marker positions are unchanged.
- Reset mid-operation:
  - rst=1 at pixel 500 with out_valid=1 and out_ready=0.
  - Next cycle: all outputs 0, no done.
  - A subsequent start restreams from address 0.
- start pulsed at cycles k+10 and k+1027 (done cycle) during a run:
  - Both pulses are ignored; exactly one done.
  - A start at k+1028 begins a new run with ce_mem in cycle k+1029.
